fp_mul_norm_round: RTL and testbench

//  Post-multiply stage of the single-precision FP multiplier. Consumes the
//  48-bit raw mantissa product from the 24x24 product stage, plus both operand

---
 rtl/fp_mul_norm_round_if.sv | 27 ++
 rtl/fp_mul_norm_round.sv | 114 +++++++++++
 tb/tb_fp_mul_norm_round.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fp_mul_norm_round_if.sv
// fp_mul_norm_round_if: valid/ready bus around the FP multiplier normalise/round stage.
// master drives operands and out_ready; slave (the stage) drives results and in_ready.
interface fp_mul_norm_round_if #(
   parameter int MANT_W = 24,
   parameter int EXP_W  = 8
);
   logic                    in_valid;
   logic                    in_ready;
   logic [2*MANT_W-1:0]     prod;
   logic [EXP_W-1:0]        exp_a;
   logic [EXP_W-1:0]        exp_b;
   logic                    sign_a;
   logic                    sign_b;
   logic                    out_valid;
   logic                    out_ready;
   logic [EXP_W+MANT_W-1:0] result;
   logic                    ovf;
   logic                    unf;
   modport master (
      output in_valid, prod, exp_a, exp_b, sign_a, sign_b, out_ready,
      input  in_ready, out_valid, result, ovf, unf
   );
   modport slave (
      input  in_valid, prod, exp_a, exp_b, sign_a, sign_b, out_ready,
      output in_ready, out_valid, result, ovf, unf
   );
endinterface

// File: rtl/fp_mul_norm_round.sv
// fp_mul_norm_round: two-stage normalise/round/special-case stage of a binary32 multiplier.
// Define FPM_RNE_ROUND_EN for round-to-nearest-even; default build truncates.
module fp_mul_norm_round #(
   parameter int MANT_W = 24,
   parameter int EXP_W  = 8,
   parameter int BIAS   = 127
) (
   input logic                clk,
   input logic                rst_n,
   fp_mul_norm_round_if.slave bus
);
   localparam int F  = MANT_W - 1;
   localparam int P  = 2 * MANT_W;
   localparam int EW = EXP_W + 2;
   localparam int W  = EXP_W + MANT_W;
   localparam logic [EXP_W-1:0]     EMAX  = '1;
   localparam logic signed [EW-1:0] E_INF = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] E_ONE = EW'(1);
   logic                 s1_v_q, s1_v_d, s2_v_q, s2_v_d;
   logic                 s1_s_q, s1_s_d;
   logic signed [EW-1:0] s1_e_q, s1_e_d;
   logic [F-1:0]         s1_mant_q, s1_mant_d;
   logic                 s1_g_q, s1_g_d, s1_st_q, s1_st_d;
   logic                 s1_nan_q, s1_nan_d, s1_inf_q, s1_inf_d, s1_zero_q, s1_zero_d;
   logic [W-1:0]         result_q, result_d;
   logic                 ovf_q, ovf_d, unf_q, unf_d;
   logic                 s2_adv, s1_adv, in_fire, s2_load;
   logic                 a_max, b_max, a_zero, b_zero, hi;
   logic                 inc, is_ovf, is_unf;
   logic [F:0]           ext;
   logic signed [EW-1:0] e_r;
   logic [W-1:0]         res;
   assign s2_adv       = !s2_v_q || bus.out_ready;
   assign s1_adv       = !s1_v_q || s2_adv;
   assign in_fire      = bus.in_valid && s1_adv;
   assign s2_load      = s2_adv && s1_v_q;
   assign bus.in_ready = s1_adv;
   assign bus.out_valid = s2_v_q;
   assign bus.result   = result_q;
   assign bus.ovf      = ovf_q;
   assign bus.unf      = unf_q;
   assign a_max  = bus.exp_a == EMAX;
   assign b_max  = bus.exp_b == EMAX;
   assign a_zero = bus.exp_a == '0;
   assign b_zero = bus.exp_b == '0;
   assign hi     = bus.prod[P-1];
   // Stage 1: align the product so the hidden bit is dropped, keep guard and sticky.
   always_comb begin
      s1_v_d    = s1_adv ? bus.in_valid : s1_v_q;
      s1_s_d    = in_fire ? bus.sign_a ^ bus.sign_b : s1_s_q;
      s1_e_d    = in_fire ? EW'(bus.exp_a) + EW'(bus.exp_b) - EW'(BIAS) + EW'(hi) : s1_e_q;
      s1_mant_d = in_fire ? (hi ? bus.prod[P-2 -: F] : bus.prod[P-3 -: F]) : s1_mant_q;
      s1_g_d    = in_fire ? (hi ? bus.prod[P-2-F] : bus.prod[P-3-F]) : s1_g_q;
      s1_st_d   = in_fire ? (hi ? |bus.prod[P-3-F:0] : |bus.prod[P-4-F:0]) : s1_st_q;
      s1_nan_d  = in_fire ? (a_max && b_zero) || (b_max && a_zero) : s1_nan_q;
      s1_inf_d  = in_fire ? a_max || b_max : s1_inf_q;
      s1_zero_d = in_fire ? a_zero || b_zero : s1_zero_q;
   end
`ifdef FPM_RNE_ROUND_EN
   assign inc = s1_g_q && (s1_st_q || s1_mant_q[0]);
`else
   logic unused_rnd;
   assign inc        = 1'b0;
   assign unused_rnd = s1_g_q ^ s1_st_q;
`endif
   // Stage 2: round, then classify; a rounding carry bumps the exponent before range checks.
   always_comb begin
      ext    = {1'b0, s1_mant_q} + (F+1)'(inc);
      e_r    = s1_e_q + EW'(ext[F]);
      is_ovf = e_r >= E_INF;
      is_unf = e_r < E_ONE;
      res    = s1_nan_q  ? {s1_s_q, EMAX, 1'b1, (F-1)'(0)} :
               s1_inf_q  ? {s1_s_q, EMAX, F'(0)} :
               s1_zero_q ? {s1_s_q, (W-1)'(0)} :
               is_ovf    ? {s1_s_q, EMAX, F'(0)} :
               is_unf    ? {s1_s_q, (W-1)'(0)} :
                           {s1_s_q, e_r[EXP_W-1:0], ext[F-1:0]};
      s2_v_d   = s2_adv ? s1_v_q : s2_v_q;
      result_d = s2_load ? res : result_q;
      ovf_d    = s2_load ? !s1_inf_q && !s1_zero_q && is_ovf : ovf_q;
      unf_d    = s2_load ? !s1_inf_q && !s1_zero_q && !is_ovf && is_unf : unf_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q    <= 1'b0;
         s1_s_q    <= 1'b0;
         s1_e_q    <= '0;
         s1_mant_q <= '0;
         s1_g_q    <= 1'b0;
         s1_st_q   <= 1'b0;
         s1_nan_q  <= 1'b0;
         s1_inf_q  <= 1'b0;
         s1_zero_q <= 1'b0;
         s2_v_q    <= 1'b0;
         result_q  <= '0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         s1_v_q    <= s1_v_d;
         s1_s_q    <= s1_s_d;
         s1_e_q    <= s1_e_d;
         s1_mant_q <= s1_mant_d;
         s1_g_q    <= s1_g_d;
         s1_st_q   <= s1_st_d;
         s1_nan_q  <= s1_nan_d;
         s1_inf_q  <= s1_inf_d;
         s1_zero_q <= s1_zero_d;
         s2_v_q    <= s2_v_d;
         result_q  <= result_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end
endmodule

// File: tb/tb_fp_mul_norm_round.sv
// tb_fp_mul_norm_round: directed bench with an in-order scoreboard of {result, ovf, unf}.
`timescale 1ns/1ps
module tb_fp_mul_norm_round;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;
   fp_mul_norm_round_if bus ();
   fp_mul_norm_round dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   int errors = 0;
   int checks = 0;
   logic [33:0] sb_q[$];
   logic [33:0] exp_in = '0;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask
   always @(negedge clk) begin
      if (rst_n && bus.in_valid && bus.in_ready) sb_q.push_back(exp_in);
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL spurious_output: got %h expected none", {bus.result, bus.ovf, bus.unf});
         end else
            check("scoreboard", {30'b0, bus.result, bus.ovf, bus.unf}, {30'b0, sb_q.pop_front()});
      end
   end
   task automatic present(input logic [47:0] p, input logic [7:0] ea, input logic [7:0] eb,
                          input logic sa, input logic sb, input logic [31:0] r, input logic [1:0] f);
      bus.prod = p; bus.exp_a = ea; bus.exp_b = eb;
      bus.sign_a = sa; bus.sign_b = sb;
      exp_in = {r, f};
      bus.in_valid = 1'b1;
   endtask
   task automatic drive(input logic [47:0] p, input logic [7:0] ea, input logic [7:0] eb,
                        input logic sa, input logic sb, input logic [31:0] r, input logic [1:0] f);
      present(p, ea, eb, sa, sb, r, f);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            return;
         end
      end
      checks++;
      errors++;
      $error("FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
      bus.in_valid = 1'b0;
   endtask
   task automatic wait_drain();
      for (int i = 0; i < 100; i++) begin
         if (sb_q.size() == 0 && !bus.out_valid) break;
         @(negedge clk);
      end
      check("drain", 64'(sb_q.size()), 64'd0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200us");
      $fatal(1, "watchdog");
   end
   initial begin
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      bus.prod = '0; bus.exp_a = '0; bus.exp_b = '0; bus.sign_a = 1'b0; bus.sign_b = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_result", 64'(bus.result), 64'd0);
      check("rst_flags", 64'({bus.ovf, bus.unf}), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;
      // T1 with latency probe
      drive(48'h900000000000, 8'd127, 8'd127, 1'b0, 1'b0, 32'h40100000, 2'b00);
      check("t1_lat_cycle1", 64'(bus.out_valid), 64'd0);
      @(posedge clk); #1;
      check("t1_lat_cycle2", 64'(bus.out_valid), 64'd1);
      wait_drain();
      // Back-to-back stream of directed cases
      drive(48'h400000000000, 8'd127, 8'd127, 1'b1, 1'b0, 32'hBF800000, 2'b00);
`ifdef FPM_RNE_ROUND_EN
      drive(48'h400000C00000, 8'd127, 8'd127, 1'b0, 1'b0, 32'h3F800002, 2'b00);
      drive(48'h7FFFFFC00000, 8'd127, 8'd127, 1'b0, 1'b0, 32'h40000000, 2'b00);
      drive(48'h7FFFFFC00000, 8'd254, 8'd127, 1'b0, 1'b0, 32'h7F800000, 2'b10);
`else
      drive(48'h400000C00000, 8'd127, 8'd127, 1'b0, 1'b0, 32'h3F800001, 2'b00);
      drive(48'h7FFFFFC00000, 8'd127, 8'd127, 1'b0, 1'b0, 32'h3FFFFFFF, 2'b00);
      drive(48'h7FFFFFC00000, 8'd254, 8'd127, 1'b0, 1'b0, 32'h7F7FFFFF, 2'b00);
`endif
      drive(48'h400000000000, 8'd254, 8'd254, 1'b0, 1'b0, 32'h7F800000, 2'b10);
      drive(48'h400000000000, 8'd1,   8'd1,   1'b0, 1'b0, 32'h00000000, 2'b01);
      drive(48'h400000000000, 8'd128, 8'd254, 1'b1, 1'b0, 32'hFF800000, 2'b10);
      drive(48'h400000000000, 8'd1,   8'd126, 1'b0, 1'b0, 32'h00000000, 2'b01);
      drive(48'h400000000000, 8'd1,   8'd127, 1'b0, 1'b0, 32'h00800000, 2'b00);
      drive(48'h400000000000, 8'd255, 8'd0,   1'b0, 1'b0, 32'h7FC00000, 2'b00);
      drive(48'h400000000000, 8'd0,   8'd255, 1'b1, 1'b0, 32'hFFC00000, 2'b00);
      drive(48'h400000000000, 8'd255, 8'd3,   1'b0, 1'b0, 32'h7F800000, 2'b00);
      drive(48'h400000000000, 8'd0,   8'd200, 1'b0, 1'b1, 32'h80000000, 2'b00);
      wait_drain();
      // T6 backpressure: two beats fill the pipe, third waits
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      drive(48'h900000000000, 8'd127, 8'd127, 1'b0, 1'b0, 32'h40100000, 2'b00);
      drive(48'h400000000000, 8'd127, 8'd127, 1'b1, 1'b0, 32'hBF800000, 2'b00);
      present(48'h400000000000, 8'd128, 8'd127, 1'b0, 1'b0, 32'h40000000, 2'b00);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t6_in_ready_low", 64'(bus.in_ready), 64'd0);
         check("t6_out_valid", 64'(bus.out_valid), 64'd1);
         check("t6_hold", 64'({bus.result, bus.ovf, bus.unf}), 64'({32'h40100000, 2'b00}));
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      drive(48'h400000000000, 8'd128, 8'd127, 1'b0, 1'b0, 32'h40000000, 2'b00);
      wait_drain();
      // Mid-stream reset drops the held beat
      bus.out_ready = 1'b0;
      drive(48'h900000000000, 8'd127, 8'd127, 1'b0, 1'b0, 32'h40100000, 2'b00);
      @(posedge clk); #1;
      check("rst_mid_pre_valid", 64'(bus.out_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_mid_result", 64'(bus.result), 64'd0);
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_mid_no_output", 64'(bus.out_valid), 64'd0);
      end
      @(posedge clk); #1;
      drive(48'h400000000000, 8'd127, 8'd127, 1'b0, 1'b1, 32'hBF800000, 2'b00);
      wait_drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
